// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: time-multiplexed driver for a 5x7 LED matrix.
// Each column slot is a dark blanking gap followed by a lit interval.
// The image is latched once per frame, so mid-scan input changes never tear.
// Outputs are decoded purely from registered state.
//
// Handshake: none. The scanner is free-running while enable is high.
// rows_values is sampled only on the edge that latches a frame, which is the
// same edge that raises frame_start for the following cycle.
`timescale 1ns/1ps
module led_matrix_scanner #(
  parameter int DWELL_CYCLES      = 50000,
  parameter int BLANK_CYCLES      = 500,
  parameter bit COLUMN_ACTIVE_LOW = 1'b1,
  parameter bit ROW_ACTIVE_LOW    = 1'b0
) (
  input  logic        _50MHz_frequency,
  input  logic        reset,
  input  logic        enable,
  input  logic [34:0] rows_values,
  output logic [4:0]  columns,
  output logic [6:0]  rows,
  output logic        frame_start,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Inactive levels for the column and row lines.
  localparam logic [4:0] COL_IDLE = {5{COLUMN_ACTIVE_LOW}};
  localparam logic [6:0] ROW_IDLE = {7{ROW_ACTIVE_LOW}};

  state_e            state_q, state_d;
  logic [2:0]        col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [34:0]       frame_q, frame_d;
  logic              frame_start_q, frame_start_d;
  logic [6:0]        row_sel;
  logic [4:0]        col_onehot;

  // State register with asynchronous reset.
  always_ff @(posedge _50MHz_frequency or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      col_q         <= 3'd0;
      cnt_q         <= '0;
      frame_q       <= 35'd0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Next-state logic; a low enable wins in every state.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    frame_d       = frame_q;
    frame_start_d = 1'b0;
    if (!enable) begin
      // Frame contents are kept; a re-enable latches a fresh image anyway.
      state_d = IDLE;
      cnt_d   = '0;
      col_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d       = BLANK;
          col_d         = 3'd0;
          cnt_d         = '0;
          frame_d       = rows_values;
          frame_start_d = 1'b1;
        end
        BLANK: begin
          // cnt keeps running into SHOW so one counter spans the whole slot.
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d   = '0;
            state_d = BLANK;
            if (col_q == 3'd4) begin
              col_d         = 3'd0;
              frame_d       = rows_values;
              frame_start_d = 1'b1;
            end else begin
              col_d = col_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          col_d   = 3'd0;
        end
      endcase
    end
  end

  // Select the 7 row bits of the current column from the latched frame.
  always_comb begin
    row_sel = 7'h00;
    case (col_q)
      3'd0:    row_sel = frame_q[6:0];
      3'd1:    row_sel = frame_q[13:7];
      3'd2:    row_sel = frame_q[20:14];
      3'd3:    row_sel = frame_q[27:21];
      3'd4:    row_sel = frame_q[34:28];
      default: row_sel = 7'h00;
    endcase
  end

  // Drive lines from registered state only; everything dark outside SHOW.
  always_comb begin
    col_onehot = 5'd1 << col_q;
    columns    = COL_IDLE;
    rows       = ROW_IDLE;
    if (state_q == SHOW) begin
      columns = COL_IDLE ^ col_onehot;
      rows    = row_sel ^ ROW_IDLE;
    end
  end

  assign frame_start = frame_start_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with DWELL_CYCLES=8, BLANK_CYCLES=2.
// Expected outputs come from the slot timing: t cycles after the enabling
// edge, column (t/8)%5 is dark for t%8<2 and lit otherwise; frame_start is
// high whenever t%40==0.
`timescale 1ns/1ps
module tb_led_matrix_scanner;

  localparam int DW = 8;
  localparam int BK = 2;
  localparam int NV = 88;
  localparam logic [34:0] IMG1 = 35'h4_0810_2040;
  localparam logic [34:0] IMG2 = 35'h3_1F2A_5C07;
  localparam logic [34:0] ONES = {35{1'b1}};

  // Clock / reset block
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [34:0] rows_values = 35'd0;
  logic [4:0]  columns;
  logic [6:0]  rows;
  logic        frame_start;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  led_matrix_scanner #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BK),
    .COLUMN_ACTIVE_LOW(1'b1),
    .ROW_ACTIVE_LOW(1'b0)
  ) dut (
    ._50MHz_frequency(clk),
    .reset(reset),
    .enable(enable),
    .rows_values(rows_values),
    .columns(columns),
    .rows(rows),
    .frame_start(frame_start),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic        en;
    logic [34:0] rv;
    logic [4:0]  cols;
    logic [6:0]  rws;
    logic        fs;
  } vec_t;

  vec_t vecs[NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected-value helpers
  function automatic logic [4:0] exp_cols(int t);
    logic [4:0] oh;
    oh = 5'd1 << ((t / DW) % 5);
    if ((t % DW) < BK) return 5'h1F;
    return ~oh;
  endfunction

  function automatic logic [6:0] exp_rows(int t, logic [34:0] img);
    int c;
    c = (t / DW) % 5;
    if ((t % DW) < BK) return 7'h00;
    return img[7*c +: 7];
  endfunction

  function automatic logic exp_fs(int t);
    return (t % (5 * DW)) == 0;
  endfunction

  // Scoreboard
  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_at(input string tag, input int t, input logic [34:0] img);
    check($sformatf("%s t=%0d columns", tag, t), {30'd0, columns}, {30'd0, exp_cols(t)});
    check($sformatf("%s t=%0d rows", tag, t), {28'd0, rows}, {28'd0, exp_rows(t, img)});
    check($sformatf("%s t=%0d frame_start", tag, t), {34'd0, frame_start}, {34'd0, exp_fs(t)});
    check($sformatf("%s t=%0d one-hot", tag, t), {34'd0, ($countones(~columns) <= 1)}, 35'd1);
  endtask

  task automatic check_dark(input string tag);
    check({tag, " columns"}, {30'd0, columns}, {30'd0, 5'h1F});
    check({tag, " rows"}, {28'd0, rows}, 35'd0);
    check({tag, " frame_start"}, {34'd0, frame_start}, 35'd0);
  endtask

  initial begin
    int last_fs;

    // Vector table: input change to IMG2 mid-frame must only show next frame.
    for (int i = 0; i < NV; i++) begin
      vecs[i].en   = 1'b1;
      vecs[i].rv   = (i < 20) ? IMG1 : IMG2;
      vecs[i].cols = exp_cols(i);
      vecs[i].rws  = exp_rows(i, (i < 40) ? IMG1 : IMG2);
      vecs[i].fs   = exp_fs(i);
    end

    // Reset asserted before any clock edge
    #1;
    check_dark("reset");

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_dark("idle after reset");

    // Scan order and anti-tearing with a mid-frame image change
    for (int i = 0; i < NV; i++) begin
      enable      = vecs[i].en;
      rows_values = vecs[i].rv;
      @(negedge clk);
      check($sformatf("vec %0d columns", i), {30'd0, columns}, {30'd0, vecs[i].cols});
      check($sformatf("vec %0d rows", i), {28'd0, rows}, {28'd0, vecs[i].rws});
      check($sformatf("vec %0d frame_start", i), {34'd0, frame_start}, {34'd0, vecs[i].fs});
    end

    // Run on into column 3 of the third frame, then disable mid-SHOW
    for (int t = NV; t < 160; t++) begin
      @(negedge clk);
      check_at("pre-disable", t, IMG2);
      if (((t / DW) % 5) == 3 && (t % DW) == 4) break;
    end
    enable = 1'b0;
    @(negedge clk);
    check_dark("disable next cycle");
    @(negedge clk);
    check_dark("disable held");

    // Re-enable with all-ones, then clear the input during column 2
    rows_values = ONES;
    enable      = 1'b1;
    @(negedge clk);
    check_at("re-enable", 0, ONES);
    for (int t = 1; t < 92; t++) begin
      @(negedge clk);
      check_at("antitear", t, (t < 40) ? ONES : 35'd0);
      if (t == 20) rows_values = 35'd0;
    end

    // At t=91 column 1 is lit; pulse reset between clock edges
    check("col1 lit before reset", {30'd0, columns}, {30'd0, 5'h1D});
    rows_values = IMG2;
    #1 reset = 1'b1;
    #1;
    check_dark("async reset");
    #1 reset = 1'b0;
    @(negedge clk);
    check_at("after reset", 0, IMG2);

    // Periodicity over five frames
    last_fs = 0;
    for (int t = 1; t <= 5 * 5 * DW; t++) begin
      @(negedge clk);
      check_at("period", t, IMG2);
      if (frame_start === 1'b1) begin
        check($sformatf("frame_start interval t=%0d", t), 35'(t - last_fs), 35'(5 * DW));
        last_fs = t;
      end
    end
    check("frame_start pulses seen", 35'(last_fs), 35'(5 * 5 * DW));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Time-multiplexed driver for the 5x7 LED matrix. It takes the 35-bit column-packed image produced by the water-tank level decoders and scans it onto the physical matrix, one column at a time. A blanking gap between columns suppresses ghosting. The image is latched once per frame so mid-scan changes never tear the display.

## Interface
Parameters:
- DWELL_CYCLES, 50000: clock cycles per column slot (blank + lit); ≥ 2.
- BLANK_CYCLES, 500: leading cycles of each slot with everything off; 1 ≤ BLANK_CYCLES < DWELL_CYCLES.
- COLUMN_ACTIVE_LOW, 1: 1 → an active column line is driven 0.
- ROW_ACTIVE_LOW, 0: 1 → a lit row line is driven 0.

Ports:
- _50MHz_frequency  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  scanning enabled; low forces IDLE.
- rows_values  in  35  image. Column c occupies bits [7c+6:7c]; bit 7c+r is row r.
- columns  out  5  column select, one-hot active in SHOW, else all inactive.
- rows  out  7  row data for the selected column, all inactive outside SHOW.
- frame_start  out  1  one-cycle pulse when a new image is latched.

## Operation
- Registers: state {IDLE, BLANK, SHOW}, col (3 bits, 0..4), cnt ($clog2(DWELL_CYCLES) bits), frame (35 bits), frame_start.
- Outputs decode from registered state only. There is no combinational path from inputs to outputs.
  - SHOW: columns[col] active, others inactive; rows[r] = frame[7·col+r], with polarity applied.
  - IDLE/BLANK: columns and rows are all inactive.
- Reset values:
  - state=IDLE, col=0, cnt=0, frame=0, frame_start=0.
  - columns = all inactive (5'b11111 with defaults); rows = all inactive (7'b0000000 with defaults).
- Transitions (evaluated each edge; enable=0 has priority in every state):
  - any state, enable=0 → IDLE, cnt=0, col=0. frame is retained.
  - IDLE, enable=1 → BLANK, col=0, cnt=0, frame←rows_values, frame_start=1.
  - BLANK: cnt+1. When cnt==BLANK_CYCLES-1 → SHOW.
  - SHOW: cnt+1. When cnt==DWELL_CYCLES-1 → cnt=0 and BLANK.
    - col<4 → col+1.
    - col==4 → col=0, frame←rows_values, frame_start=1.
- frame_start is 0 on every other edge, so it is exactly one cycle wide.
- rows_values is sampled only at frame latch. Changes at any other time have no effect until the next frame.

## Timing
- Column slot = DWELL_CYCLES cycles: BLANK_CYCLES dark, then DWELL_CYCLES−BLANK_CYCLES lit.
- Frame period = 5·DWELL_CYCLES cycles. frame_start pulses exactly once per period.
- Enable latency:
  - frame_start is high in the cycle after the enabling edge.
  - Column 0 lights BLANK_CYCLES cycles after BLANK is entered.
- Disable latency: outputs go inactive one cycle after enable is sampled low.
- Re-enable always restarts at column 0 with a fresh latch. A partial frame is never resumed.
- Asynchronous reset mid-scan: outputs go inactive immediately, without waiting for a clock edge. Scanning resumes per the IDLE rule after reset deasserts.
- No two columns are ever simultaneously active. Every column change passes through ≥ BLANK_CYCLES dark cycles, including the 4→0 wrap.

## Test plan
Bench parameters: DWELL_CYCLES=8, BLANK_CYCLES=2, defaults otherwise.
- **Reset:** assert reset with no clock. Required: columns=5'b11111, rows=7'h00, frame_start=0 immediately.
- **Scan order:** enable=1 with rows_values=35'h4_0810_2040.
  - frame_start=1 for exactly one cycle.
  - Per column: 2 dark cycles, then 6 cycles with columns=~(1<<c).
  - Columns appear in order 0,1,2,3,4,0.
  - rows equals bits [7c+6:7c] of the input.
- **Anti-tearing:** during column 2 of a frame, change rows_values from all-ones to 0. Required: columns 3–4 still show 7'h7F; column 0 of the next frame shows 7'h00 after frame_start.
- **Periodicity:** run 5 frames. Required: frame_start pulses every 40 cycles exactly; no cycle has >1 active column.
- **Disable mid-SHOW:** drop enable during column 3. Required: all outputs inactive on the next cycle. On re-enable, frame_start pulses and the scan restarts at column 0.
- **Async reset mid-scan:** pulse reset between clock edges while column 1 is lit. Required: outputs inactive before the next edge. After release with enable=1, frame_start pulses on the first edge.
